// File: rtl/instrument_decoder.sv
// instrument_decoder: routes one-hot-ID frames to per-channel note/strum state.
// Define INST_TIMEOUT_EN to add per-channel silence clearing after TIMEOUT_CYCLES.
module instrument_decoder #(
  parameter int NUM_INST = 3,
  parameter int NOTE_W = 5,
  parameter int STRUM_LEN = 4,
  parameter int TIMEOUT_CYCLES = 2700000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_INST+NOTE_W-1:0] rx_data,
  input  logic                       rx_valid,
  output logic [NUM_INST*NOTE_W-1:0] notes,
  output logic [NUM_INST-1:0]        active,
  output logic [NUM_INST-1:0]        strum,
  output logic                       rx_seen,
  output logic [7:0]                 bad_id_cnt
);
  localparam int SW = $clog2(STRUM_LEN + 1);
  logic [NUM_INST-1:0] id;
  logic [NOTE_W-1:0] note;
  logic one_hot;
  assign id = rx_data[NUM_INST-1:0];
  assign note = rx_data[NUM_INST+NOTE_W-1:NUM_INST];
  assign one_hot = $countones(id) == 1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_seen <= 1'b0;
      bad_id_cnt <= '0;
    end else begin
      rx_seen <= rx_valid;
      if (rx_valid && !one_hot && bad_id_cnt != 8'hff) bad_id_cnt <= bad_id_cnt + 8'd1;
    end
  for (genvar i = 0; i < NUM_INST; i++) begin : g_ch
    logic [NOTE_W-1:0] n_q;
    logic a_q;
    logic [SW-1:0] scnt;
    logic hit, expire;
    assign hit = rx_valid && one_hot && id[i];
`ifdef INST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tcnt;
    assign expire = tcnt == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge rst)
      if (rst) tcnt <= '0;
      else if (hit || expire) tcnt <= '0;
      else if (a_q) tcnt <= tcnt + TW'(1);
`else
    assign expire = 1'b0;
`endif
    // a frame outranks both expiry and the strum countdown
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        n_q <= '0;
        a_q <= 1'b0;
        scnt <= '0;
      end else if (hit) begin
        n_q <= note;
        a_q <= note != '0;
        scnt <= note != '0 ? SW'(STRUM_LEN) : '0;
      end else if (expire) begin
        n_q <= '0;
        a_q <= 1'b0;
        scnt <= '0;
      end else if (scnt != '0) scnt <= scnt - SW'(1);
    assign notes[i*NOTE_W +: NOTE_W] = n_q;
    assign active[i] = a_q;
    assign strum[i] = scnt != '0;
  end
endmodule

// File: tb/tb_instrument_decoder.sv
// tb_instrument_decoder: directed table plus hand sequences for strum, saturation, timeout and reset.
module tb_instrument_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic [14:0] notes;
  logic [2:0] active, strum;
  logic rx_seen;
  logic [7:0] bad_id_cnt;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [7:0]  d;
    logic        v;
    logic [14:0] n;
    logic [2:0]  a;
    logic [2:0]  s;
    logic        seen;
    logic [7:0]  b;
  } vec_t;
  vec_t tbl[8];

  instrument_decoder #(.NUM_INST(3), .NOTE_W(5), .STRUM_LEN(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .notes(notes),
    .active(active), .strum(strum), .rx_seen(rx_seen), .bad_id_cnt(bad_id_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic frame(input logic [7:0] d);
    rx_data = d;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic strum_run(input logic [7:0] d1, input logic [7:0] d2, input int t2, input int ch,
                           output int cnt, output int rises);
    logic prev;
    cnt = 0;
    rises = 0;
    prev = 1'b0;
    for (int c = 0; c < 12; c++) begin
      rx_valid = (c == 0) || (c == t2);
      rx_data = (c == 0) ? d1 : d2;
      @(negedge clk);
      rx_valid = 1'b0;
      if (strum[ch]) cnt++;
      if (strum[ch] && !prev) rises++;
      prev = strum[ch];
    end
  endtask

  initial begin
    int cnt, rises;
    tbl[0] = '{8'b10110_001, 1'b1, 15'h0016, 3'b001, 3'b001, 1'b1, 8'd0};
    tbl[1] = '{8'b00011_100, 1'b1, 15'h0C16, 3'b101, 3'b101, 1'b1, 8'd0};
    tbl[2] = '{8'b00001_011, 1'b1, 15'h0C16, 3'b101, 3'b101, 1'b1, 8'd1};
    tbl[3] = '{8'b00001_000, 1'b1, 15'h0C16, 3'b101, 3'b101, 1'b1, 8'd2};
    tbl[4] = '{8'b00000_000, 1'b0, 15'h0C16, 3'b101, 3'b100, 1'b0, 8'd2};
    tbl[5] = '{8'b00000_100, 1'b1, 15'h0016, 3'b001, 3'b000, 1'b1, 8'd2};
    tbl[6] = '{8'b00111_010, 1'b1, 15'h00F6, 3'b011, 3'b010, 1'b1, 8'd2};
    tbl[7] = '{8'b11111_111, 1'b1, 15'h00F6, 3'b011, 3'b010, 1'b1, 8'd3};
    repeat (2) @(negedge clk);
    check("reset_notes", 32'(notes), 0);
    check("reset_active", 32'(active), 0);
    check("reset_strum", 32'(strum), 0);
    check("reset_seen", 32'(rx_seen), 0);
    check("reset_bad", 32'(bad_id_cnt), 0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rx_data = tbl[k].d;
      rx_valid = tbl[k].v;
      @(negedge clk);
      rx_valid = 1'b0;
      check($sformatf("tbl%0d_notes", k), 32'(notes), 32'(tbl[k].n));
      check($sformatf("tbl%0d_active", k), 32'(active), 32'(tbl[k].a));
      check($sformatf("tbl%0d_strum", k), 32'(strum), 32'(tbl[k].s));
      check($sformatf("tbl%0d_seen", k), 32'(rx_seen), 32'(tbl[k].seen));
      check($sformatf("tbl%0d_bad", k), 32'(bad_id_cnt), 32'(tbl[k].b));
    end

    do_reset();
    strum_run(8'b10110_001, 8'h00, -1, 0, cnt, rises);
    check("single_strum_len", 32'(cnt), 4);
    check("single_strum_rises", 32'(rises), 1);
    check("single_notes", 32'(notes), 32'h0016);
    strum_run(8'b00111_010, 8'b00111_010, 2, 1, cnt, rises);
    check("retrig_strum_len", 32'(cnt), 6);
    check("retrig_strum_rises", 32'(rises), 1);
    strum_run(8'b00011_100, 8'b00000_100, 2, 2, cnt, rises);
    check("cut_strum_len", 32'(cnt), 2);
    check("cut_active2", 32'(active), 32'b011);
    check("cut_notes", 32'(notes), 32'h00F6);

    rx_data = 8'b01010_000;
    rx_valid = 1'b1;
    repeat (300) @(negedge clk);
    rx_valid = 1'b0;
    check("sat_bad", 32'(bad_id_cnt), 255);
    check("sat_notes", 32'(notes), 32'h00F6);
    check("sat_active", 32'(active), 32'b011);

    do_reset();
    frame(8'b00011_001);
    repeat (98) @(negedge clk);
    check("to_active_99", 32'(active), 32'b001);
    @(negedge clk);
    check("to_active_100", 32'(active), 32'b001);
    @(negedge clk);
`ifdef INST_TIMEOUT_EN
    check("to_cleared_active", 32'(active), 0);
    check("to_cleared_notes", 32'(notes), 0);
`else
    repeat (900) @(negedge clk);
    check("noto_active", 32'(active), 32'b001);
    check("noto_notes", 32'(notes), 32'h0003);
`endif

    do_reset();
    frame(8'b00001_001);
    frame(8'b00010_010);
    frame(8'b00011_100);
    #2 rst = 1'b1;
    #1;
    check("async_notes", 32'(notes), 0);
    check("async_active", 32'(active), 0);
    check("async_strum", 32'(strum), 0);
    check("async_seen", 32'(rx_seen), 0);
    @(negedge clk);
    rst = 1'b0;
    frame(8'b01001_100);
    check("post_rst_notes", 32'(notes), 32'h2400);
    check("post_rst_active", 32'(active), 32'b100);
    check("post_rst_strum", 32'(strum), 32'b100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
